// File: rtl/riscv_hazard_unit_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
//   hzrd_state_t : mul/div occupancy FSM states
//   RESULT_*     : E-stage result source encodings (RESULT_MEM marks a load)
//   FWD_*        : E-stage operand forward selects
package riscv_hzrd_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } hzrd_state_t;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/riscv_hazard_unit_if.sv
// Pipeline-side bundle of the hazard unit.
//   i_* : register addresses, write-back info, branch, mul/div and dcache status
//   o_* : hold enables (stall_*), bubble loads (flush_*), forward selects,
//         mul/div busy and watchdog timeout pulse
// slave  : the hazard unit (consumes i_*, drives o_*)
// master : the pipeline (drives i_*, consumes o_*)
interface riscv_hazard_unit_if;

  logic [4:0] i_riscv_hzrd_rs1addr_d;
  logic [4:0] i_riscv_hzrd_rs2addr_d;
  logic [4:0] i_riscv_hzrd_rs1addr_e;
  logic [4:0] i_riscv_hzrd_rs2addr_e;
  logic [4:0] i_riscv_hzrd_rdaddr_e;
  logic [1:0] i_riscv_hzrd_resultsrc_e;
  logic [4:0] i_riscv_hzrd_rdaddr_m;
  logic       i_riscv_hzrd_regwrite_m;
  logic [4:0] i_riscv_hzrd_rdaddr_w;
  logic       i_riscv_hzrd_regwrite_w;
  logic       i_riscv_hzrd_pcsrc_e;
  logic       i_riscv_hzrd_mdu_start_e;
  logic       i_riscv_hzrd_mdu_done;
  logic       i_riscv_hzrd_dcache_stall;

  logic       o_riscv_hzrd_stall_f;
  logic       o_riscv_hzrd_stall_d;
  logic       o_riscv_hzrd_stall_e;
  logic       o_riscv_hzrd_stall_m;
  logic       o_riscv_hzrd_stall_w;
  logic       o_riscv_hzrd_flush_d;
  logic       o_riscv_hzrd_flush_e;
  logic       o_riscv_hzrd_flush_m;
  logic [1:0] o_riscv_hzrd_fwda_e;
  logic [1:0] o_riscv_hzrd_fwdb_e;
  logic       o_riscv_hzrd_mdu_busy;
  logic       o_riscv_hzrd_mdu_timeout;

  modport slave (
    input  i_riscv_hzrd_rs1addr_d, i_riscv_hzrd_rs2addr_d,
           i_riscv_hzrd_rs1addr_e, i_riscv_hzrd_rs2addr_e,
           i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_resultsrc_e,
           i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_regwrite_m,
           i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w,
           i_riscv_hzrd_pcsrc_e, i_riscv_hzrd_mdu_start_e,
           i_riscv_hzrd_mdu_done, i_riscv_hzrd_dcache_stall,
    output o_riscv_hzrd_stall_f, o_riscv_hzrd_stall_d, o_riscv_hzrd_stall_e,
           o_riscv_hzrd_stall_m, o_riscv_hzrd_stall_w,
           o_riscv_hzrd_flush_d, o_riscv_hzrd_flush_e, o_riscv_hzrd_flush_m,
           o_riscv_hzrd_fwda_e, o_riscv_hzrd_fwdb_e,
           o_riscv_hzrd_mdu_busy, o_riscv_hzrd_mdu_timeout
  );

  modport master (
    output i_riscv_hzrd_rs1addr_d, i_riscv_hzrd_rs2addr_d,
           i_riscv_hzrd_rs1addr_e, i_riscv_hzrd_rs2addr_e,
           i_riscv_hzrd_rdaddr_e, i_riscv_hzrd_resultsrc_e,
           i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_regwrite_m,
           i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w,
           i_riscv_hzrd_pcsrc_e, i_riscv_hzrd_mdu_start_e,
           i_riscv_hzrd_mdu_done, i_riscv_hzrd_dcache_stall,
    input  o_riscv_hzrd_stall_f, o_riscv_hzrd_stall_d, o_riscv_hzrd_stall_e,
           o_riscv_hzrd_stall_m, o_riscv_hzrd_stall_w,
           o_riscv_hzrd_flush_d, o_riscv_hzrd_flush_e, o_riscv_hzrd_flush_m,
           o_riscv_hzrd_fwda_e, o_riscv_hzrd_fwdb_e,
           o_riscv_hzrd_mdu_busy, o_riscv_hzrd_mdu_timeout
  );

endinterface

// File: rtl/riscv_hazard_unit_fwd.sv
// Forwarding comparator for one E-stage source operand.
//   i_rs_e               : E-stage source register
//   i_rd_m/i_regwrite_m  : M-stage destination and write enable
//   i_rd_w/i_regwrite_w  : W-stage destination and write enable
//   o_fwd                : FWD_M, FWD_W or FWD_NONE (M wins over W, x0 never forwards)
module riscv_hzrd_fwd
  import riscv_hzrd_pkg::*;
(
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rd_m,
  input  logic       i_regwrite_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_regwrite_w,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_NONE;
    if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_M;
    end else if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard unit: hold enables and bubble loads for the F/D, D/E, E/M
// and M/W registers, plus E-stage forward selects.
//   i_riscv_hzrd_clk / i_riscv_hzrd_rst_n : clock, async active-low reset
//   hz (slave)                            : pipeline status in, controls out
// Priority: dcache freeze > mul/div hold > taken branch > load-use.
module riscv_hazard_unit
  import riscv_hzrd_pkg::*;
#(
  parameter int unsigned MDU_MAX_CYCLES = 70,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                i_riscv_hzrd_clk,
  input  logic                i_riscv_hzrd_rst_n,
  riscv_hazard_unit_if.slave  hz
);

  hzrd_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic       frozen, finish, timeout, mdu_hold, load_use;
  logic [1:0] fwda, fwdb;

  riscv_hzrd_fwd u_fwd_a (
    .i_rs_e       (hz.i_riscv_hzrd_rs1addr_e),
    .i_rd_m       (hz.i_riscv_hzrd_rdaddr_m),
    .i_regwrite_m (hz.i_riscv_hzrd_regwrite_m),
    .i_rd_w       (hz.i_riscv_hzrd_rdaddr_w),
    .i_regwrite_w (hz.i_riscv_hzrd_regwrite_w),
    .o_fwd        (fwda)
  );

  riscv_hzrd_fwd u_fwd_b (
    .i_rs_e       (hz.i_riscv_hzrd_rs2addr_e),
    .i_rd_m       (hz.i_riscv_hzrd_rdaddr_m),
    .i_regwrite_m (hz.i_riscv_hzrd_regwrite_m),
    .i_rd_w       (hz.i_riscv_hzrd_rdaddr_w),
    .i_regwrite_w (hz.i_riscv_hzrd_regwrite_w),
    .o_fwd        (fwdb)
  );

  always_ff @(posedge i_riscv_hzrd_clk or negedge i_riscv_hzrd_rst_n) begin
    if (!i_riscv_hzrd_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Mul/div occupancy FSM. A done that arrives during a cache freeze is
  // remembered in done_q so the op can release once the freeze lifts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    timeout  = 1'b0;
    mdu_hold = 1'b0;
    frozen   = hz.i_riscv_hzrd_dcache_stall;
    finish   = hz.i_riscv_hzrd_mdu_done || done_q;
    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (hz.i_riscv_hzrd_mdu_start_e && !hz.i_riscv_hzrd_mdu_done) begin
          mdu_hold = 1'b1;
          if (!frozen) begin
            state_d = S_BUSY;
            cnt_d   = '0;
          end
        end
      end
      S_BUSY: begin
        timeout  = !frozen && !finish && (cnt_q == CNT_W'(MDU_MAX_CYCLES - 1));
        mdu_hold = !finish && !timeout;
        if (frozen) begin
          if (hz.i_riscv_hzrd_mdu_done) done_d = 1'b1;
        end else if (finish || timeout) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_use = (hz.i_riscv_hzrd_resultsrc_e == RESULT_MEM) &&
               (hz.i_riscv_hzrd_rdaddr_e != '0) &&
               ((hz.i_riscv_hzrd_rdaddr_e == hz.i_riscv_hzrd_rs1addr_d) ||
                (hz.i_riscv_hzrd_rdaddr_e == hz.i_riscv_hzrd_rs2addr_d));

    hz.o_riscv_hzrd_stall_f     = 1'b0;
    hz.o_riscv_hzrd_stall_d     = 1'b0;
    hz.o_riscv_hzrd_stall_e     = 1'b0;
    hz.o_riscv_hzrd_stall_m     = 1'b0;
    hz.o_riscv_hzrd_stall_w     = 1'b0;
    hz.o_riscv_hzrd_flush_d     = 1'b0;
    hz.o_riscv_hzrd_flush_e     = 1'b0;
    hz.o_riscv_hzrd_flush_m     = 1'b0;
    hz.o_riscv_hzrd_fwda_e      = fwda;
    hz.o_riscv_hzrd_fwdb_e      = fwdb;
    hz.o_riscv_hzrd_mdu_busy    = (state_q == S_BUSY);
    hz.o_riscv_hzrd_mdu_timeout = timeout;

    if (frozen) begin
      hz.o_riscv_hzrd_stall_f = 1'b1;
      hz.o_riscv_hzrd_stall_d = 1'b1;
      hz.o_riscv_hzrd_stall_e = 1'b1;
      hz.o_riscv_hzrd_stall_m = 1'b1;
      hz.o_riscv_hzrd_stall_w = 1'b1;
    end else if (mdu_hold) begin
      hz.o_riscv_hzrd_stall_f = 1'b1;
      hz.o_riscv_hzrd_stall_d = 1'b1;
      hz.o_riscv_hzrd_stall_e = 1'b1;
      hz.o_riscv_hzrd_flush_m = 1'b1;
    end else if (hz.i_riscv_hzrd_pcsrc_e) begin
      hz.o_riscv_hzrd_flush_d = 1'b1;
      hz.o_riscv_hzrd_flush_e = 1'b1;
    end else if (load_use) begin
      hz.o_riscv_hzrd_stall_f = 1'b1;
      hz.o_riscv_hzrd_stall_d = 1'b1;
      hz.o_riscv_hzrd_flush_e = 1'b1;
    end

    // Combinational paths (forwarding, priority chain) must also read 0 in reset.
    if (!i_riscv_hzrd_rst_n) begin
      hz.o_riscv_hzrd_stall_f     = 1'b0;
      hz.o_riscv_hzrd_stall_d     = 1'b0;
      hz.o_riscv_hzrd_stall_e     = 1'b0;
      hz.o_riscv_hzrd_stall_m     = 1'b0;
      hz.o_riscv_hzrd_stall_w     = 1'b0;
      hz.o_riscv_hzrd_flush_d     = 1'b0;
      hz.o_riscv_hzrd_flush_e     = 1'b0;
      hz.o_riscv_hzrd_flush_m     = 1'b0;
      hz.o_riscv_hzrd_fwda_e      = FWD_NONE;
      hz.o_riscv_hzrd_fwdb_e      = FWD_NONE;
      hz.o_riscv_hzrd_mdu_busy    = 1'b0;
      hz.o_riscv_hzrd_mdu_timeout = 1'b0;
    end
  end

endmodule
